// File: rtl/easyaxi_pkg.sv
// Shared encodings for the EasyAXI slaves: burst types, response codes and the
// read beat-generator state.
package easyaxi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST
  } rd_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/easyaxi_sync_fifo.sv
// Pointer-plus-count synchronous FIFO with show-ahead read data; push is dropped
// when full and pop is ignored when empty.
module easyaxi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by cnt.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/easyaxi_rd_slv.sv
// AXI read-only synthetic-memory slave: rdata = {rid, beat address}, first beat
// 2+RD_LAT cycles after AR; R payload is registered and held until rready.
module easyaxi_rd_slv #(
  parameter int              ID_W          = 4,
  parameter int              ADDR_W        = 16,
  parameter int              DATA_W        = 32,
  parameter int              OST_DEPTH     = 4,
  parameter int              MAX_BURST_LEN = 16,
  parameter int              RD_LAT        = 0,
  parameter longint unsigned BASE_ADDR     = 0,
  parameter longint unsigned ADDR_SPAN     = 64'd1 << ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           axi_slv_arvalid,
  output logic                           axi_slv_arready,
  input  logic [ID_W-1:0]                axi_slv_arid,
  input  logic [ADDR_W-1:0]              axi_slv_araddr,
  input  logic [7:0]                     axi_slv_arlen,
  input  logic [2:0]                     axi_slv_arsize,
  input  logic [1:0]                     axi_slv_arburst,
  output logic                           axi_slv_rvalid,
  input  logic                           axi_slv_rready,
  output logic [ID_W-1:0]                axi_slv_rid,
  output logic [DATA_W-1:0]              axi_slv_rdata,
  output logic [1:0]                     axi_slv_rresp,
  output logic                           axi_slv_rlast,
  output logic [$clog2(OST_DEPTH+2)-1:0] ost_cnt
);

  import easyaxi_pkg::*;

  localparam int              OST_W   = $clog2(OST_DEPTH+2);
  localparam longint unsigned WIN_END = BASE_ADDR + ADDR_SPAN;
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    burst_e            burst;
    resp_e             err;
  } req_t;

  req_t              ar_req;
  req_t              head;
  req_t              cur;
  logic              fifo_full;
  logic              fifo_empty;
  logic              ar_hs;
  logic              r_done;
  logic              beat_hs;
  logic              pop;
  logic              start;
  rd_state_e         state;
  rd_state_e         state_n;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        beat_cnt;
  logic [3:0]        lat_cnt;
  logic [63:0]       ar_addr64;
  logic              decerr;
  logic              slverr;
  req_t              src;

  assign axi_slv_arready = enable & ~fifo_full & ~rst;
  assign ar_hs           = axi_slv_arvalid & axi_slv_arready;
  assign beat_hs         = axi_slv_rvalid & axi_slv_rready;
  assign r_done          = beat_hs & axi_slv_rlast;

  // Request classification happens once, at push time.
  assign ar_addr64 = 64'(axi_slv_araddr);
  assign decerr    = (ar_addr64 < BASE_ADDR) || (ar_addr64 >= WIN_END);
  assign slverr    = ((int'(axi_slv_arlen) + 1) > MAX_BURST_LEN)
                  || ((32'd1 << axi_slv_arsize) > 32'(DATA_W/8))
                  || (axi_slv_arburst == BURST_RSVD)
                  || ((axi_slv_arburst == BURST_WRAP) && !wrap_len_ok(axi_slv_arlen));

  always_comb begin
    ar_req       = '0;
    ar_req.id    = axi_slv_arid;
    ar_req.addr  = axi_slv_araddr;
    ar_req.len   = axi_slv_arlen;
    ar_req.size  = axi_slv_arsize;
    ar_req.burst = burst_e'(axi_slv_arburst);
    ar_req.err   = decerr ? RESP_DECERR : (slverr ? RESP_SLVERR : RESP_OKAY);
  end

  easyaxi_sync_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (OST_DEPTH)
  ) u_ar_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (ar_hs),
    .push_dat (ar_req),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    start   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (RD_LAT == 0) begin
            state_n = ST_BURST;
            start   = 1'b1;
          end else begin
            state_n = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (lat_cnt <= 4'd1) begin
          state_n = ST_BURST;
          start   = 1'b1;
        end
      end
      ST_BURST: begin
        if (axi_slv_rready && axi_slv_rlast) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // First beat comes straight from the FIFO head when there is no latency,
  // otherwise from the request latched at pop.
  assign src = (state == ST_IDLE) ? head : cur;

  always_comb begin
    logic [ADDR_W-1:0] nb;
    logic [ADDR_W-1:0] ws;
    logic [ADDR_W-1:0] lo;
    logic [ADDR_W-1:0] inc;
    nb  = A_ONE << cur.size;
    ws  = ADDR_W'(nb * (ADDR_W'(cur.len) + A_ONE));
    lo  = cur.addr & ~(ws - A_ONE);
    inc = cur_addr + nb;
    case (cur.burst)
      BURST_INCR: addr_nxt = (cur_addr & ~(nb - A_ONE)) + nb;
      BURST_WRAP: addr_nxt = (inc == lo + ws) ? lo : inc;
      default:    addr_nxt = cur_addr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur            <= '0;
      cur_addr       <= '0;
      beat_cnt       <= '0;
      lat_cnt        <= '0;
      axi_slv_rvalid <= 1'b0;
      axi_slv_rlast  <= 1'b0;
      axi_slv_rid    <= '0;
      axi_slv_rdata  <= '0;
      axi_slv_rresp  <= RESP_OKAY;
    end else begin
      if (pop) begin
        cur      <= head;
        cur_addr <= head.addr;
        beat_cnt <= '0;
        lat_cnt  <= 4'(RD_LAT);
      end else if (state == ST_WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
      end

      if (start) begin
        axi_slv_rvalid <= 1'b1;
        axi_slv_rid    <= src.id;
        axi_slv_rdata  <= DATA_W'({src.id, src.addr});
        axi_slv_rresp  <= src.err;
        axi_slv_rlast  <= (src.len == 8'd0);
      end else if (beat_hs) begin
        if (axi_slv_rlast) begin
          axi_slv_rvalid <= 1'b0;
        end else begin
          cur_addr      <= addr_nxt;
          beat_cnt      <= beat_cnt + 8'd1;
          axi_slv_rdata <= DATA_W'({cur.id, addr_nxt});
          axi_slv_rlast <= ((beat_cnt + 8'd1) == cur.len);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ost_cnt <= '0;
    end else begin
      case ({ar_hs, r_done})
        2'b10:   ost_cnt <= ost_cnt + OST_W'(1);
        2'b01:   ost_cnt <= ost_cnt - OST_W'(1);
        default: ost_cnt <= ost_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_easyaxi_rd_slv.sv
// Bench for easyaxi_rd_slv: dut0 has no latency and a full window, dut1 has
// RD_LAT=3 and a 0x1000..0x1FFF window; a select bit steers handshakes to one.
module tb_easyaxi_rd_slv;

  logic        clk = 1'b0;
  logic        rst, enable, arvalid, rready, sel;
  logic [3:0]  arid;
  logic [15:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        arready0, arready1, rvalid0, rvalid1, rlast0, rlast1;
  logic [3:0]  rid0, rid1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  rresp0, rresp1;
  logic [2:0]  ost0, ost1;

  logic        arready, rvalid, rlast;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [2:0]  ost;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign arready = sel ? arready1 : arready0;
  assign rvalid  = sel ? rvalid1  : rvalid0;
  assign rlast   = sel ? rlast1   : rlast0;
  assign rid     = sel ? rid1     : rid0;
  assign rdata   = sel ? rdata1   : rdata0;
  assign rresp   = sel ? rresp1   : rresp0;
  assign ost     = sel ? ost1     : ost0;

  easyaxi_rd_slv #(
    .ID_W(4), .ADDR_W(16), .DATA_W(32), .OST_DEPTH(4), .MAX_BURST_LEN(16),
    .RD_LAT(0), .BASE_ADDR(64'h0), .ADDR_SPAN(64'h10000)
  ) dut0 (
    .clk(clk), .rst(rst), .enable(enable),
    .axi_slv_arvalid(arvalid & ~sel), .axi_slv_arready(arready0),
    .axi_slv_arid(arid), .axi_slv_araddr(araddr), .axi_slv_arlen(arlen),
    .axi_slv_arsize(arsize), .axi_slv_arburst(arburst),
    .axi_slv_rvalid(rvalid0), .axi_slv_rready(rready & ~sel),
    .axi_slv_rid(rid0), .axi_slv_rdata(rdata0), .axi_slv_rresp(rresp0),
    .axi_slv_rlast(rlast0), .ost_cnt(ost0)
  );

  easyaxi_rd_slv #(
    .ID_W(4), .ADDR_W(16), .DATA_W(32), .OST_DEPTH(4), .MAX_BURST_LEN(16),
    .RD_LAT(3), .BASE_ADDR(64'h1000), .ADDR_SPAN(64'h1000)
  ) dut1 (
    .clk(clk), .rst(rst), .enable(enable),
    .axi_slv_arvalid(arvalid & sel), .axi_slv_arready(arready1),
    .axi_slv_arid(arid), .axi_slv_araddr(araddr), .axi_slv_arlen(arlen),
    .axi_slv_arsize(arsize), .axi_slv_arburst(arburst),
    .axi_slv_rvalid(rvalid1), .axi_slv_rready(rready & sel),
    .axi_slv_rid(rid1), .axi_slv_rdata(rdata1), .axi_slv_rresp(rresp1),
    .axi_slv_rlast(rlast1), .ost_cnt(ost1)
  );

  typedef struct {
    logic        s;
    logic [3:0]  id;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  resp;
    int          beats;
    int          first;
    logic [15:0] a[4];
    int          nchk;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic s, input logic [3:0] id, input logic [15:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [1:0] resp,
                              input int beats, input int first,
                              input logic [15:0] a0, input logic [15:0] a1,
                              input logic [15:0] a2, input logic [15:0] a3, input int nchk);
    vec_t v;
    v.s = s; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.resp = resp; v.beats = beats; v.first = first;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3; v.nchk = nchk;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive_ar(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, beats, first;
    bit done;
    logic [31:0] exp_d;
    sel    = v.s;
    rready = 1'b1;
    @(negedge clk);
    drive_ar(v.id, v.addr, v.len, v.size, v.burst);
    chk($sformatf("v%0d_arready", idx), arready, 1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    cyc = 1; beats = 0; first = -1; done = 0;
    while (!done && cyc < 100) begin
      if (rvalid) begin
        if (first < 0) first = cyc;
        if (beats < v.nchk) begin
          exp_d = {12'h000, v.id, v.a[beats]};
          chk($sformatf("v%0d_rdata_b%0d", idx, beats), rdata, exp_d);
        end
        chk($sformatf("v%0d_rid_b%0d", idx, beats), rid, v.id);
        chk($sformatf("v%0d_rresp_b%0d", idx, beats), rresp, v.resp);
        chk($sformatf("v%0d_rlast_b%0d", idx, beats), rlast, (beats == v.beats - 1));
        beats++;
        if (rlast) done = 1;
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk($sformatf("v%0d_done", idx), done, 1);
    chk($sformatf("v%0d_first_cycle", idx), first, v.first);
    chk($sformatf("v%0d_beats", idx), beats, v.beats);
    @(negedge clk);
    chk($sformatf("v%0d_ost_after", idx), ost, 0);
    chk($sformatf("v%0d_rvalid_after", idx), rvalid, 0);
  endtask

  initial begin
    int cyc, beats, first, got;
    bit stalled;
    logic [3:0]  pat;
    logic [31:0] sv_data, exp_d;
    logic        sv_last;

    // sel, id, addr, len, size, burst, resp, beats, first, a0..a3, nchk
    vecs[0]  = mk(0, 4'h5, 16'h0010, 3,  2, 2'b01, 2'b00, 4,  2, 16'h0010, 16'h0014, 16'h0018, 16'h001C, 4);
    vecs[1]  = mk(0, 4'h3, 16'h0034, 3,  2, 2'b10, 2'b00, 4,  2, 16'h0034, 16'h0038, 16'h003C, 16'h0030, 4);
    vecs[2]  = mk(0, 4'h1, 16'h0040, 2,  2, 2'b10, 2'b10, 3,  2, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 1);
    vecs[3]  = mk(1, 4'h2, 16'h2000, 0,  2, 2'b01, 2'b11, 1,  5, 16'h2000, 16'h0000, 16'h0000, 16'h0000, 1);
    vecs[4]  = mk(1, 4'h4, 16'h1100, 1,  3, 2'b01, 2'b10, 2,  5, 16'h1100, 16'h1108, 16'h0000, 16'h0000, 2);
    vecs[5]  = mk(1, 4'h6, 16'h1200, 16, 2, 2'b01, 2'b10, 17, 5, 16'h1200, 16'h1204, 16'h1208, 16'h120C, 4);
    vecs[6]  = mk(0, 4'h7, 16'h0100, 0,  0, 2'b00, 2'b00, 1,  2, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1);
    vecs[7]  = mk(0, 4'h8, 16'h0200, 2,  2, 2'b00, 2'b00, 3,  2, 16'h0200, 16'h0200, 16'h0200, 16'h0000, 3);
    vecs[8]  = mk(0, 4'hB, 16'h0013, 2,  2, 2'b01, 2'b00, 3,  2, 16'h0013, 16'h0014, 16'h0018, 16'h0000, 3);
    vecs[9]  = mk(0, 4'hC, 16'h0300, 0,  2, 2'b11, 2'b10, 1,  2, 16'h0300, 16'h0000, 16'h0000, 16'h0000, 1);
    vecs[10] = mk(0, 4'hF, 16'h0000, 15, 0, 2'b01, 2'b00, 16, 2, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 4);
    vecs[11] = mk(0, 4'hD, 16'hFFFC, 1,  2, 2'b01, 2'b00, 2,  2, 16'hFFFC, 16'h0000, 16'h0000, 16'h0000, 2);
    vecs[12] = mk(1, 4'hE, 16'h0FFF, 0,  0, 2'b01, 2'b11, 1,  5, 16'h0FFF, 16'h0000, 16'h0000, 16'h0000, 1);
    vecs[13] = mk(1, 4'h9, 16'h1FFF, 0,  0, 2'b01, 2'b00, 1,  5, 16'h1FFF, 16'h0000, 16'h0000, 16'h0000, 1);

    rst = 1'b1; enable = 1'b1; arvalid = 1'b0; rready = 1'b0; sel = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    repeat (2) @(negedge clk);
    chk("rst_arready0", arready0, 0);
    chk("rst_arready1", arready1, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_ost", ost, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_arready", arready, 1);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Latency plus backpressure: rready follows 1,0,0,1 per cycle.
    sel = 1'b1; pat = 4'b1001; rready = 1'b0;
    @(negedge clk);
    drive_ar(4'h9, 16'h1400, 7, 2, 2'b01);
    chk("bp_arready", arready, 1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    cyc = 1; beats = 0; first = -1; stalled = 0; sv_data = '0; sv_last = 1'b0;
    while (beats < 8 && cyc < 200) begin
      rready = pat[cyc % 4];
      if (rvalid) begin
        if (first < 0) first = cyc;
        if (stalled) begin
          chk("bp_stable_rdata", rdata, sv_data);
          chk("bp_stable_rlast", rlast, sv_last);
        end
        exp_d = 32'h0009_1400 + 32'(4 * beats);
        chk($sformatf("bp_rdata_b%0d", beats), rdata, exp_d);
        if (rready) begin
          chk($sformatf("bp_rlast_b%0d", beats), rlast, (beats == 7));
          beats++;
          stalled = 0;
        end else begin
          stalled = 1;
          sv_data = rdata;
          sv_last = rlast;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("bp_first_cycle", first, 5);
    chk("bp_beats", beats, 8);
    chk("bp_no_extra_beat", rvalid, 0);
    rready = 1'b1;
    @(negedge clk);
    chk("bp_ost_after", ost, 0);

    // Fill: 4 queued + 1 in flight, sixth AR refused.
    sel = 1'b0; rready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_ar(4'(i), 16'h0100 + 16'(16 * i), 0, 2, 2'b01);
      chk($sformatf("full_arready_%0d", i), arready, (i < 5));
      @(posedge clk);
    end
    repeat (3) begin
      @(negedge clk);
      chk("full_arready_hold", arready, 0);
    end
    arvalid = 1'b0;
    chk("full_ost", ost, 5);
    rready = 1'b1;
    got = 0; cyc = 0;
    while (got < 6 && cyc < 40) begin
      if (rvalid) begin
        exp_d = {12'h000, 4'(got), 16'h0100 + 16'(16 * got)};
        chk($sformatf("order_rid_%0d", got), rid, got);
        chk($sformatf("order_rdata_%0d", got), rdata, exp_d);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("order_count", got, 5);
    chk("order_ost_after", ost, 0);

    // enable low refuses AR.
    @(negedge clk);
    enable = 1'b0;
    drive_ar(4'h1, 16'h0020, 0, 2, 2'b01);
    #1 chk("enable_low_arready", arready, 0);
    repeat (3) @(negedge clk);
    arvalid = 1'b0;
    chk("enable_low_ost", ost, 0);
    chk("enable_low_rvalid", rvalid, 0);
    enable = 1'b1;

    // Reset during beat 2 of a len-7 burst.
    @(negedge clk);
    drive_ar(4'hA, 16'h0500, 7, 2, 2'b01);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    beats = 0; cyc = 0;
    while (!(rvalid && beats == 1) && cyc < 20) begin
      if (rvalid) beats++;
      @(negedge clk);
      cyc++;
    end
    chk("rstmid_reached_beat2", (rvalid && beats == 1), 1);
    chk("rstmid_beat2_data", rdata, 32'h000A_0504);
    rst = 1'b1;
    #1;
    chk("rstmid_rvalid", rvalid, 0);
    chk("rstmid_ost", ost, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_ost_after", ost, 0);
    chk("rstmid_rvalid_after", rvalid, 0);
    run_vec(100, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
